// File: rtl/rx_packet_fifo.sv
// rx_packet_fifo
// Packet-mode receive buffer for the async_receiver byte stream. Bytes are
// stored speculatively as they arrive. Only packets closed by an
// end-of-packet strobe become visible to the consumer. A packet that runs
// out of storage is discarded whole by rewinding the write pointer.
//
// Ports
//   clk              system clock
//   rst_n            synchronous active-low reset
//   RxD_data_ready   byte strobe, RxD_data valid
//   RxD_data         received byte
//   RxD_endofpacket  closes the current packet
//   out_ready        consumer accepts the head byte
//   ovf_clr          clears the sticky overflow flag
//   out_valid        head byte belongs to a committed packet
//   out_data         head byte (show-ahead)
//   out_last         head byte ends its packet
//   pkt_count        complete packets held
//   overflow         sticky, a byte was dropped for lack of space
//   drop_count       packets discarded, saturating at 255
module rx_packet_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RxD_data_ready,
    input  logic [7:0]    RxD_data,
    input  logic          RxD_endofpacket,
    input  logic          out_ready,
    input  logic          ovf_clr,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic [AW:0]   pkt_count,
    output logic          overflow,
    output logic [7:0]    drop_count
);

    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    logic [7:0]       r_mem_data [DEPTH];
    logic [DEPTH-1:0] r_mem_last;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_wr_commit;
    logic [AW:0]      r_rd_ptr;
    logic             r_err;
    logic [AW:0]      r_pkt_count;
    logic             r_overflow;
    logic [7:0]       r_drop_count;

    logic [AW:0]      w_occ;
    logic             w_full;
    logic             w_wr_en;
    logic             w_drop_byte;
    logic             w_err_eff;
    logic [AW:0]      w_wr_next;
    logic             w_commit;
    logic             w_discard;
    logic [AW-1:0]    w_last_idx;
    logic             w_head_last;
    logic             w_pop;
    logic             w_pop_last;

    // Full is judged on the registered pointers only, so a pop in the same
    // cycle does not make room for an incoming byte.
    assign w_occ       = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_occ == DEPTH_P);
    assign w_wr_en     = RxD_data_ready & ~r_err & ~w_full;
    assign w_drop_byte = RxD_data_ready & ~r_err & w_full;

    // A byte arriving with the end-of-packet strobe is handled first, so it
    // is either part of the commit or the cause of the discard.
    assign w_err_eff   = r_err | w_drop_byte;
    assign w_wr_next   = r_wr_ptr + {{AW{1'b0}}, w_wr_en};
    assign w_commit    = RxD_endofpacket & ~w_err_eff & (w_wr_next != r_wr_commit);
    assign w_discard   = RxD_endofpacket & w_err_eff;
    assign w_last_idx  = w_wr_next[AW-1:0] - AW'(1);

    assign out_valid   = (r_rd_ptr != r_wr_commit);
    assign out_data    = r_mem_data[r_rd_ptr[AW-1:0]];
    assign w_head_last = r_mem_last[r_rd_ptr[AW-1:0]];
    assign out_last    = out_valid & w_head_last;
    assign w_pop       = out_valid & out_ready;
    assign w_pop_last  = w_pop & w_head_last;

    assign pkt_count   = r_pkt_count;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_wr_en) begin
                r_mem_data[r_wr_ptr[AW-1:0]] <= RxD_data;
                r_mem_last[r_wr_ptr[AW-1:0]] <= 1'b0;
            end
            // Placed after the byte write so a byte closing its own packet
            // ends up with the last flag set.
            if (w_commit) begin
                r_mem_last[w_last_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_wr_commit  <= '0;
            r_rd_ptr     <= '0;
            r_err        <= 1'b0;
            r_pkt_count  <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_wr_ptr <= w_discard ? r_wr_commit : w_wr_next;
            r_err    <= w_discard ? 1'b0 : w_err_eff;

            if (w_commit) begin
                r_wr_commit <= w_wr_next;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end

            case ({w_commit, w_pop_last})
                2'b10:   r_pkt_count <= r_pkt_count + (AW+1)'(1);
                2'b01:   r_pkt_count <= r_pkt_count - (AW+1)'(1);
                default: r_pkt_count <= r_pkt_count;
            endcase

            if (w_drop_byte) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_discard && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_packet_fifo.sv
// tb_rx_packet_fifo
// Bench for rx_packet_fifo: a table of per-cycle vectors, hand-written
// sequences for overflow/drain/wrap/reset cases, and a randomized phase
// compared against a queue-based packet model.
module tb_rx_packet_fifo;

    logic       clk;
    logic       rst_n;
    logic       rdy;
    logic [7:0] din;
    logic       eop;
    logic       ordy;
    logic       clr;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;
    logic [4:0] o_pkt;
    logic       o_ovf;
    logic [7:0] o_drop;

    rx_packet_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .RxD_data_ready  (rdy),
        .RxD_data        (din),
        .RxD_endofpacket (eop),
        .out_ready       (ordy),
        .ovf_clr         (clr),
        .out_valid       (o_valid),
        .out_data        (o_data),
        .out_last        (o_last),
        .pkt_count       (o_pkt),
        .overflow        (o_ovf),
        .drop_count      (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: committed entries {last, byte}, pending packet bytes
    logic [8:0] m_cq[$];
    logic [7:0] m_pq[$];
    bit         m_err;
    bit         m_ovf;
    int         m_drop;
    bit         model_on = 0;

    logic [8:0] rcv[$];
    bit         rcv_on = 0;

    typedef struct {
        logic       rdy;
        logic [7:0] d;
        logic       eop;
        logic       ordy;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic [4:0] ep;
        logic       eo;
        logic [7:0] edr;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cq.delete();
        m_pq.delete();
        m_err  = 0;
        m_ovf  = 0;
        m_drop = 0;
    endtask

    task automatic model_step();
        int occ;
        bit full;
        bit pop;
        bit dropped;
        occ     = m_cq.size() + m_pq.size();
        full    = (occ == 16);
        pop     = (m_cq.size() > 0) && ordy;
        dropped = 0;
        if (rdy && !m_err) begin
            if (full) begin
                m_err   = 1;
                m_ovf   = 1;
                dropped = 1;
            end else begin
                m_pq.push_back(din);
            end
        end
        if (clr && !dropped) m_ovf = 0;
        if (pop) void'(m_cq.pop_front());
        if (eop) begin
            if (m_err) begin
                m_pq.delete();
                m_err = 0;
                if (m_drop < 255) m_drop++;
            end else if (m_pq.size() > 0) begin
                foreach (m_pq[i]) m_cq.push_back({(i == m_pq.size() - 1), m_pq[i]});
                m_pq.delete();
            end
        end
    endtask

    task automatic model_check();
        int np;
        np = 0;
        foreach (m_cq[i]) if (m_cq[i][8]) np++;
        chk("rnd_valid", o_valid, (m_cq.size() > 0));
        if (m_cq.size() > 0) begin
            chk("rnd_data", o_data, m_cq[0][7:0]);
            chk("rnd_last", o_last, m_cq[0][8]);
        end
        chk("rnd_pkt", o_pkt, np);
        chk("rnd_ovf", o_ovf, m_ovf);
        chk("rnd_drop", o_drop, m_drop);
    endtask

    task automatic step();
        if (rcv_on && o_valid && ordy) rcv.push_back({o_last, o_data});
        @(posedge clk);
        if (model_on && rst_n) model_step();
        #1;
    endtask

    task automatic drive(input logic r, input logic [7:0] d, input logic e,
                         input logic o, input logic c);
        rdy  = r;
        din  = d;
        eop  = e;
        ordy = o;
        clr  = c;
        step();
    endtask

    task automatic idle();
        drive(0, 8'h00, 0, 0, 0);
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] d, input logic l);
        chk({nm, "_valid"}, o_valid, 1'b1);
        chk({nm, "_data"}, o_data, d);
        chk({nm, "_last"}, o_last, l);
        drive(0, 8'h00, 0, 1, 0);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_valid"}, o_valid, 1'b0);
        chk({nm, "_last"}, o_last, 1'b0);
        chk({nm, "_pkt"}, o_pkt, 5'd0);
        chk({nm, "_ovf"}, o_ovf, 1'b0);
        chk({nm, "_drop"}, o_drop, 8'd0);
    endtask

    initial begin
        rst_n = 0; rdy = 0; din = 0; eop = 0; ordy = 0; clr = 0;

        // three-byte packet drained with ready high, then empty eop and
        // byte+eop in the same cycle
        vt[0] = '{1, 8'h11, 0, 1,  0, 8'h00, 0, 5'd0, 0, 8'd0};
        vt[1] = '{1, 8'h22, 0, 1,  0, 8'h00, 0, 5'd0, 0, 8'd0};
        vt[2] = '{1, 8'h33, 0, 1,  0, 8'h00, 0, 5'd0, 0, 8'd0};
        vt[3] = '{0, 8'h00, 1, 0,  1, 8'h11, 0, 5'd1, 0, 8'd0};
        vt[4] = '{0, 8'h00, 0, 1,  1, 8'h22, 0, 5'd1, 0, 8'd0};
        vt[5] = '{0, 8'h00, 0, 1,  1, 8'h33, 1, 5'd1, 0, 8'd0};
        vt[6] = '{0, 8'h00, 0, 1,  0, 8'h00, 0, 5'd0, 0, 8'd0};
        vt[7] = '{0, 8'h00, 1, 0,  0, 8'h00, 0, 5'd0, 0, 8'd0};
        vt[8] = '{1, 8'h7E, 1, 0,  1, 8'h7E, 1, 5'd1, 0, 8'd0};
        vt[9] = '{0, 8'h00, 0, 1,  0, 8'h00, 0, 5'd0, 0, 8'd0};

        step();
        step();
        check_reset_vals("reset");
        rst_n = 1;
        idle();

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].rdy, vt[i].d, vt[i].eop, vt[i].ordy, 1'b0);
            chk($sformatf("vec%0d_valid", i), o_valid, vt[i].ev);
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_data", i), o_data, vt[i].ed);
                chk($sformatf("vec%0d_last", i), o_last, vt[i].el);
            end
            chk($sformatf("vec%0d_pkt", i), o_pkt, vt[i].ep);
            chk($sformatf("vec%0d_ovf", i), o_ovf, vt[i].eo);
            chk($sformatf("vec%0d_drop", i), o_drop, vt[i].edr);
        end

        // two packets held, then drained
        drive(1, 8'hA5, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        drive(1, 8'h01, 0, 0, 0);
        drive(1, 8'h02, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        idle();
        chk("two_pkt", o_pkt, 5'd2);
        pop_expect("two_a5", 8'hA5, 1);
        chk("two_pkt_after1", o_pkt, 5'd1);
        pop_expect("two_01", 8'h01, 0);
        pop_expect("two_02", 8'h02, 1);
        chk("two_empty", o_valid, 1'b0);
        chk("two_pkt_end", o_pkt, 5'd0);

        // oversize packet is dropped whole
        for (int i = 0; i < 18; i++) drive(1, 8'(8'h40 + i), 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        chk("ovs_ovf", o_ovf, 1'b1);
        chk("ovs_drop", o_drop, 8'd1);
        chk("ovs_valid", o_valid, 1'b0);
        chk("ovs_pkt", o_pkt, 5'd0);
        drive(1, 8'h5A, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        chk("ovs_next_pkt", o_pkt, 5'd1);
        pop_expect("ovs_5a", 8'h5A, 1);
        chk("ovs_next_empty", o_valid, 1'b0);

        // 14 committed bytes, then a 4-byte packet that cannot fit
        drive(0, 8'h00, 0, 0, 1);
        chk("fit_ovf_clr0", o_ovf, 1'b0);
        for (int i = 0; i < 14; i++) drive(1, 8'(8'h10 + i), 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        chk("fit_pkt1", o_pkt, 5'd1);
        for (int i = 0; i < 4; i++) drive(1, 8'(8'hC0 + i), 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        chk("fit_ovf", o_ovf, 1'b1);
        chk("fit_drop", o_drop, 8'd2);
        chk("fit_pkt_kept", o_pkt, 5'd1);
        for (int i = 0; i < 14; i++) pop_expect($sformatf("fit_b%0d", i), 8'(8'h10 + i), (i == 13));
        chk("fit_empty", o_valid, 1'b0);
        chk("fit_pkt0", o_pkt, 5'd0);
        drive(0, 8'h00, 0, 0, 1);
        chk("fit_ovf_clr", o_ovf, 1'b0);

        // wrap-around: 40 single-byte packets, consumer ready every other cycle
        rcv.delete();
        rcv_on = 1;
        for (int i = 0; i < 40; i++) begin
            drive(1, 8'(i), 1, 1'b0, 0);
            drive(0, 8'h00, 0, 1'b1, 0);
        end
        for (int k = 0; k < 40 && o_valid; k++) drive(0, 8'h00, 0, 1, 0);
        rcv_on = 0;
        chk("wrap_count", rcv.size(), 40);
        foreach (rcv[i]) chk($sformatf("wrap_%0d", i), rcv[i], {1'b1, 8'(i)});
        chk("wrap_drop", o_drop, 8'd2);
        chk("wrap_pkt", o_pkt, 5'd0);

        // reset with a committed packet held and another half-received
        drive(1, 8'h99, 1, 0, 0);
        drive(1, 8'h01, 0, 0, 0);
        drive(1, 8'h02, 0, 0, 0);
        rst_n = 0;
        drive(1, 8'h03, 1, 1, 0);
        check_reset_vals("mid_rst");
        rst_n = 1;
        model_reset();
        model_on = 1;
        idle();
        drive(0, 8'h00, 1, 0, 0);
        chk("mid_rst_eop_valid", o_valid, 1'b0);
        chk("mid_rst_eop_pkt", o_pkt, 5'd0);
        chk("mid_rst_eop_drop", o_drop, 8'd0);

        // randomized traffic against the packet model
        for (int seg = 0; seg < 15; seg++) begin
            int rp;
            rp = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 200; c++) begin
                drive(($urandom_range(0, 99) < 65),
                      8'($urandom),
                      ($urandom_range(0, 99) < 9),
                      ($urandom_range(0, 99) < rp),
                      ($urandom_range(0, 99) < 3));
                model_check();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_packet_fifo.md
# rx_packet_fifo

Packet-mode receive buffer that sits directly downstream of `async_receiver`. It captures each byte flagged by `RxD_data_ready`, groups bytes into packets delimited by `RxD_endofpacket`, and releases only complete packets to the consumer through a valid/ready stream with an end-of-packet marker. A packet that overflows the buffer is discarded whole, never partially delivered.

## Interface
- `DEPTH`, 16: byte storage entries; power of two, ≥ 4.
- `AW`, 4: log2(`DEPTH`).

- `clk`  in  1  system clock (100 MHz in the UART subsystem).
- `rst_n`  in  1  reset; synchronous, active-low.
- `RxD_data_ready`  in  1  one-cycle strobe; `RxD_data` is valid.
- `RxD_data`  in  8  received byte.
- `RxD_endofpacket`  in  1  one-cycle strobe; the current packet is closed.
- `out_ready`  in  1  consumer accepts `out_data`.
- `ovf_clr`  in  1  clears the sticky `overflow` flag.
- `out_valid`  out  1  `out_data`/`out_last` are valid; the byte belongs to a committed packet.
- `out_data`  out  8  head byte.
- `out_last`  out  1  head byte is the final byte of its packet.
- `pkt_count`  out  AW+1  number of complete packets held.
- `overflow`  out  1  sticky; set when any byte is dropped because storage is full.
- `drop_count`  out  8  packets discarded; saturates at 255.

## Operation
- Storage: `DEPTH` × 9 bits (byte + last flag). Pointers are AW+1 bits: `wr_ptr` (speculative write), `wr_commit` (end of the last committed packet), and `rd_ptr`.
- Occupancy = `wr_ptr − rd_ptr` (mod 2^(AW+1)). Full when occupancy == `DEPTH`.
- Byte write: on `RxD_data_ready`, if not full and not `err`, write {0, `RxD_data`} at `wr_ptr` and increment `wr_ptr`. If full, drop the byte, set `err` (internal, per packet) and set `overflow`. While `err` is set, all further bytes are ignored.
- Commit, on `RxD_endofpacket`:
  - `err`=0 and `wr_ptr`≠`wr_commit`: set the last flag of entry `wr_ptr−1`, set `wr_commit`←`wr_ptr`, and increment `pkt_count`.
  - `err`=1: rewind `wr_ptr`←`wr_commit`, clear `err`, and increment `drop_count` (saturating).
  - Empty packet (`wr_ptr`==`wr_commit`, `err`=0): no action.
- Read: `out_valid` = (`rd_ptr` ≠ `wr_commit`). `out_data`/`out_last` are read combinationally from entry `rd_ptr` (show-ahead). When `out_valid`&`out_ready`, increment `rd_ptr`. If the popped entry has `out_last`=1, decrement `pkt_count`.
- Simultaneous `RxD_data_ready` and `RxD_endofpacket`: the byte is written first and is included in the commit; its last flag is set. The same ordering applies under `err`: the byte is dropped and then the rewind happens.
- Simultaneous commit and pop-of-last: `pkt_count` is unchanged.
- A pop in the same cycle frees one entry for the write in that cycle only if full is evaluated after the pop. Required: full is evaluated on the registered pointers, so a write while full is dropped even if a pop coincides.
- A packet longer than `DEPTH` bytes always overflows and is dropped.
- `ovf_clr` clears `overflow`. If `ovf_clr` coincides with a new drop, set wins.

## Timing
- Reset (`rst_n`=0 at a `clk` edge): all pointers are 0, `err`=0, `out_valid`=0, `out_last`=0, `pkt_count`=0, `overflow`=0, `drop_count`=0. `out_data` is don't-care while `out_valid`=0. Memory contents are not reset.
- Reset mid-packet or mid-read discards all contents. Strobes sampled in the reset cycle are ignored.
- Write latency: the byte is stored at the edge where `RxD_data_ready`=1.
- Commit latency: `out_valid` rises in the cycle after the `RxD_endofpacket` edge. `pkt_count` updates at the same edge.
- Throughput: one pop per cycle. Back-to-back `out_ready` drains a packet of N bytes in N cycles.
- `out_data`, `out_last` and `out_valid` hold stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset, then 3 bytes 0x11, 0x22, 0x33 followed by `RxD_endofpacket`, with `out_ready`=1. Required: `out_valid` stays 0 before the commit, `pkt_count`=1 after it, the outputs are 0x11, 0x22, 0x33 with `out_last` only on 0x33, and `pkt_count` returns to 0.
- Two packets {0xA5} and {0x01, 0x02} with `out_ready`=0. Required: `pkt_count`=2. Then drain: 0xA5 (last), 0x01, 0x02 (last).
- `DEPTH`+2 = 18 bytes then end-of-packet. Required: `overflow`=1, `drop_count`=1, `out_valid`=0, `pkt_count`=0. A following packet {0x5A} then delivers normally.
- Commit packet {0x10 … 0x1D} (14 bytes), then a 4-byte packet with `out_ready`=0. Required: the second packet is dropped and the first is delivered intact. `ovf_clr` then clears `overflow`.
- `RxD_endofpacket` with no bytes pending. Required: no change in `pkt_count` or `drop_count`. Also assert `RxD_data_ready`=1 with 0x7E in the same cycle as `RxD_endofpacket`. Required: a 1-byte packet 0x7E with `out_last`=1.
- Wrap-around: 40 single-byte packets 0x00..0x27, consumed with `out_ready` toggling every cycle. Required: in-order delivery with no loss. Then assert `rst_n`=0 mid-packet. Required: all outputs return to their reset values.
